key_dir_ctrl: RTL and testbench

KEY_DIR_CTRL -- requirements
Module: key_dir_ctrl

---
 rtl/key_dir_ctrl.sv | 126 ++++++++++++
 tb/tb_key_dir_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_dir_ctrl.sv
// Two-button snake steering: each active-low key is synchronized and debounced into a
// one-cycle press pulse, and presses queue a single left/right turn applied on the next step.
module key_dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       key1,
    input  logic       key2,
    input  logic       step,
    output logic [1:0] dir,
    output logic       key1_press,
    output logic       key2_press,
    output logic       dir_valid,
    output logic [1:0] o_dbg_req
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_LEFT  = 2'd1,
        REQ_RIGHT = 2'd2
    } req_t;

    // Bit 0 is key1 (turn left), bit 1 is key2 (turn right).
    logic [1:0]    w_key_raw;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_stable;
    logic [1:0]    r_stable_d;
    logic [1:0]    r_fall;
    logic [1:0]    r_press;
    logic [CW-1:0] r_cnt [2];

    req_t          r_req;
    req_t          w_req_next;
    logic [1:0]    r_dir;
    logic [1:0]    w_dir_next;
    logic          w_turn;
    logic          r_turned;
    logic          r_dir_valid;

    assign w_key_raw = {key2, key1};

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            r_sync1    <= 2'b11;
            r_sync2    <= 2'b11;
            r_stable   <= 2'b11;
            r_stable_d <= 2'b11;
            r_fall     <= 2'b00;
            r_press    <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1    <= w_key_raw;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            // Falling edge of the stable level is retimed twice so a press lands DEBOUNCE_CYCLES+3 edges after the key is first sampled low.
            r_fall     <= r_stable_d & ~r_stable;
            r_press    <= r_fall;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    // A step consumes the pending request first; a press in the same cycle then becomes the new pending request.
    always_comb begin
        w_req_next = r_req;
        w_dir_next = r_dir;
        w_turn     = 1'b0;
        if (step) begin
            case (r_req)
                REQ_LEFT: begin
                    w_dir_next = r_dir - 2'd1;
                    w_turn     = 1'b1;
                end
                REQ_RIGHT: begin
                    w_dir_next = r_dir + 2'd1;
                    w_turn     = 1'b1;
                end
                default: begin
                    w_dir_next = r_dir;
                end
            endcase
            w_req_next = REQ_NONE;
        end
        if (r_press[0] && !r_press[1]) begin
            w_req_next = REQ_LEFT;
        end else if (r_press[1] && !r_press[0]) begin
            w_req_next = REQ_RIGHT;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            r_req       <= REQ_NONE;
            r_dir       <= 2'd1;
            r_turned    <= 1'b0;
            r_dir_valid <= 1'b0;
        end else begin
            r_req       <= w_req_next;
            r_dir       <= w_dir_next;
            r_turned    <= w_turn;
            r_dir_valid <= r_turned;
        end
    end

    assign dir        = r_dir;
    assign key1_press = r_press[0];
    assign key2_press = r_press[1];
    assign dir_valid  = r_dir_valid;
    assign o_dbg_req  = r_req;

endmodule

// File: tb/tb_key_dir_ctrl.sv
// Bench for key_dir_ctrl: directed scenarios plus random key/step traffic, checked every
// cycle against a window-based debounce model and a turn-queue model of the heading.
module tb_key_dir_ctrl;

    localparam int D     = 4;
    localparam int MAX_E = 4096;

    logic       clk_in;
    logic       rst;
    logic       key1;
    logic       key2;
    logic       step;
    logic [1:0] dir;
    logic       key1_press;
    logic       key2_press;
    logic       dir_valid;
    logic [1:0] o_dbg_req;

    int checks = 0;
    int errors = 0;
    int e      = 0;

    // Reference model state.
    logic hist1[$];
    logic hist2[$];
    logic m_stab1;
    logic m_stab2;
    int   m_pend;
    int   m_dir;
    bit   exp_p1 [MAX_E];
    bit   exp_p2 [MAX_E];
    bit   exp_dv [MAX_E];

    key_dir_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .key1      (key1),
        .key2      (key2),
        .step      (step),
        .dir       (dir),
        .key1_press(key1_press),
        .key2_press(key2_press),
        .dir_valid (dir_valid),
        .o_dbg_req (o_dbg_req)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s edge=%0d got=%0h expected=%0h", tag, e, obs, exp_v);
        end
    endtask

    // A key's stable level flips once the last D samples seen past the 2-flop synchronizer all disagree with it.
    function automatic bit window_differs(input int which, input logic s);
        int n;
        logic v;
        n = (which == 0) ? hist1.size() : hist2.size();
        for (int k = 0; k < D; k++) begin
            v = (which == 0) ? hist1[n-3-k] : hist2[n-3-k];
            if (v === s) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge(input logic k1, input logic k2, input logic st, input logic rs);
        bit p1;
        bit p2;
        if (!rs) begin
            hist1.delete();
            hist2.delete();
            for (int i = 0; i < D + 2; i++) begin
                hist1.push_back(1'b1);
                hist2.push_back(1'b1);
            end
            m_stab1 = 1'b1;
            m_stab2 = 1'b1;
            m_pend  = 0;
            m_dir   = 1;
            for (int i = 0; i < 3; i++) begin
                exp_p1[e+i] = 1'b0;
                exp_p2[e+i] = 1'b0;
                exp_dv[e+i] = 1'b0;
            end
        end else begin
            p1 = exp_p1[e-1];
            p2 = exp_p2[e-1];
            hist1.push_back(k1);
            hist2.push_back(k2);
            if (window_differs(0, m_stab1)) begin
                m_stab1 = ~m_stab1;
                if (!m_stab1) exp_p1[e+2] = 1'b1;
            end
            if (window_differs(1, m_stab2)) begin
                m_stab2 = ~m_stab2;
                if (!m_stab2) exp_p2[e+2] = 1'b1;
            end
            if (st) begin
                if (m_pend != 0) begin
                    m_dir = (m_dir + m_pend + 4) % 4;
                    exp_dv[e+1] = 1'b1;
                end
                m_pend = 0;
            end
            if (p1 && !p2) m_pend = -1;
            else if (p2 && !p1) m_pend = 1;
            while (hist1.size() > D + 4) void'(hist1.pop_front());
            while (hist2.size() > D + 4) void'(hist2.pop_front());
        end
    endtask

    task automatic run_cycle(input logic k1, input logic k2, input logic st, input logic rs);
        key1 = k1;
        key2 = k2;
        step = st;
        rst  = rs;
        @(posedge clk_in);
        #1;
        model_edge(k1, k2, st, rs);
        check("key1_press", {3'b0, key1_press}, {3'b0, exp_p1[e]});
        check("key2_press", {3'b0, key2_press}, {3'b0, exp_p2[e]});
        check("dir_valid",  {3'b0, dir_valid},  {3'b0, exp_dv[e]});
        check("dir",        {2'b0, dir},        4'(m_dir));
        e++;
    endtask

    task automatic hold(input logic k1, input logic k2, input int n);
        for (int i = 0; i < n; i++) run_cycle(k1, k2, 1'b0, 1'b1);
    endtask

    task automatic do_step();
        run_cycle(1'b1, 1'b1, 1'b1, 1'b1);
        hold(1'b1, 1'b1, 3);
    endtask

    task automatic press1();
        hold(1'b0, 1'b1, 10);
        hold(1'b1, 1'b1, 8);
    endtask

    task automatic press2();
        hold(1'b1, 1'b0, 10);
        hold(1'b1, 1'b1, 8);
    endtask

    initial begin
        logic lvl1;
        logic lvl2;
        int   left1;
        int   left2;
        rst  = 1'b0;
        key1 = 1'b1;
        key2 = 1'b1;
        step = 1'b0;

        repeat (3) run_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("req_reset", {2'b0, o_dbg_req}, 4'd0);

        // Idle keys: steps never turn.
        repeat (20) begin
            run_cycle(1'b1, 1'b1, 1'b1, 1'b1);
            run_cycle(1'b1, 1'b1, 1'b0, 1'b1);
        end
        check("idle_dir", {2'b0, dir}, 4'd1);

        // Single left press then step: 1 -> 0.
        press1();
        do_step();
        check("left_dir", {2'b0, dir}, 4'd0);

        // Short key2 glitch is ignored.
        hold(1'b1, 1'b0, 3);
        hold(1'b1, 1'b1, 10);
        do_step();
        check("glitch_dir", {2'b0, dir}, 4'd0);

        // Left then right without step: only the newer right turn applies, once.
        press1();
        press2();
        do_step();
        check("overwrite_dir", {2'b0, dir}, 4'd1);
        do_step();
        check("second_step_dir", {2'b0, dir}, 4'd1);

        // Four left turns from 0 wrap 3,2,1,0.
        press1();
        do_step();
        check("to_zero_dir", {2'b0, dir}, 4'd0);
        for (int i = 0; i < 4; i++) begin
            press1();
            do_step();
            check("wrap_dir", {2'b0, dir}, 4'(3 - i));
        end

        // Both keys together: no request.
        hold(1'b0, 1'b0, 10);
        hold(1'b1, 1'b1, 8);
        do_step();
        check("both_dir", {2'b0, dir}, 4'd0);

        // Reset mid-debounce with key held: latency restarts from release.
        hold(1'b0, 1'b1, 5);
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("rst_dir", {2'b0, dir}, 4'd1);
        hold(1'b0, 1'b1, 7);
        check("rst_press_early", {3'b0, key1_press}, 4'd0);
        hold(1'b0, 1'b1, 1);
        check("rst_press_at7", {3'b0, key1_press}, 4'd1);
        hold(1'b0, 1'b1, 3);
        hold(1'b1, 1'b1, 8);
        do_step();
        check("rst_turn_dir", {2'b0, dir}, 4'd0);

        // Random key levels, steps and occasional resets.
        lvl1  = 1'b1;
        lvl2  = 1'b1;
        left1 = $urandom_range(1, 8);
        left2 = $urandom_range(1, 8);
        for (int c = 0; c < 1500; c++) begin
            if (left1 == 0) begin
                lvl1  = ~lvl1;
                left1 = $urandom_range(1, 8);
            end
            if (left2 == 0) begin
                lvl2  = ~lvl2;
                left2 = $urandom_range(1, 8);
            end
            run_cycle(lvl1, lvl2, ($urandom_range(0, 5) == 0), ($urandom_range(0, 299) != 0));
            left1--;
            left2--;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
